// File: rtl/array_lab_pkg.sv
// Constants and loader state encoding shared by the array loader and the summing FSM.
// States RB_ADDR/RB_CMP exist only when ARRAY_MEM_LOADER_VERIFY_EN is defined.
package array_lab_pkg;

    localparam int ARRAY_DEPTH    = 8;
    localparam int ARRAY_DATA_W   = 8;
    localparam int ARRAY_ADDR_W   = 5;
    localparam int DEBOUNCE_50MHZ = 500000;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PRESS   = 3'd1;
    localparam logic [2:0] ST_WRITE   = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_FULL    = 3'd4;
`ifdef ARRAY_MEM_LOADER_VERIFY_EN
    localparam logic [2:0] ST_RB_ADDR = 3'd5;
    localparam logic [2:0] ST_RB_CMP  = 3'd6;
`endif

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stable-level debouncer for a raw push button.
// Emits the debounced level, a "change pending" flag and a one-cycle rise pulse.
module btn_debounce
    import array_lab_pkg::*;
#(
    parameter int CYCLES = DEBOUNCE_50MHZ
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic pending,
    output logic rise
);

    localparam int              CNT_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_reg;
    logic             btn_s_reg;
    logic             level_reg;
    logic             rise_reg;
    logic [CNT_W-1:0] cnt_reg;

    // The counter only runs while the synchronized input disagrees with the
    // debounced level, so any bounce back to the old level restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg  <= 1'b0;
            btn_s_reg <= 1'b0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync_reg  <= btn_raw;
            btn_s_reg <= sync_reg;
            rise_reg  <= 1'b0;
            if (btn_s_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                cnt_reg   <= '0;
                level_reg <= btn_s_reg;
                rise_reg  <= btn_s_reg;
            end else begin
                cnt_reg <= cnt_reg + CNT_ONE;
            end
        end
    end

    assign level   = level_reg;
    assign pending = (btn_s_reg != level_reg);
    assign rise    = rise_reg;

endmodule

// File: rtl/array_mem_loader.sv
// Loads DEPTH switch values into array_mem, one per debounced button press.
// Define ARRAY_MEM_LOADER_VERIFY_EN to read back each write and flag mismatches.
module array_mem_loader
    import array_lab_pkg::*;
#(
    parameter int DATA_W          = ARRAY_DATA_W,
    parameter int ADDR_W          = ARRAY_ADDR_W,
    parameter int DEPTH           = ARRAY_DEPTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_btn,
    input  logic              clear,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] count,
    output logic              full,
    output logic              wr_pulse,
    output logic              verify_err
);

    localparam logic [ADDR_W-1:0] COUNT_FULL = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

    logic [2:0]        state_reg;
    logic [2:0]        state_next;
    logic [ADDR_W-1:0] count_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              btn_level;
    logic              btn_pending;
    logic              btn_rise;
    logic              at_depth;

    btn_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (load_btn),
        .level   (btn_level),
        .pending (btn_pending),
        .rise    (btn_rise)
    );

    assign at_depth = (count_reg == COUNT_FULL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (btn_rise && !at_depth) begin
                        state_next = ST_WRITE;
                    end else if (btn_pending && !btn_level) begin
                        state_next = ST_PRESS;
                    end
                end
                ST_PRESS: begin
                    if (btn_rise && !at_depth) begin
                        state_next = ST_WRITE;
                    end else if (!btn_pending) begin
                        state_next = ST_IDLE;
                    end
                end
`ifdef ARRAY_MEM_LOADER_VERIFY_EN
                ST_WRITE:   state_next = ST_RB_ADDR;
                ST_RB_ADDR: state_next = ST_RB_CMP;
                ST_RB_CMP:  state_next = ST_RELEASE;
`else
                ST_WRITE:   state_next = ST_RELEASE;
`endif
                // Wait for a debounced release so a held button writes only once.
                ST_RELEASE: begin
                    if (!btn_level) begin
                        state_next = at_depth ? ST_FULL : ST_IDLE;
                    end
                end
                ST_FULL:    state_next = ST_FULL;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_wren  = 1'b0;
        wr_pulse  = 1'b0;
        mem_addr  = count_reg;
        mem_wdata = wdata_reg;
        full      = 1'b0;
        case (state_reg)
            ST_WRITE: begin
                if (!clear) begin
                    mem_wren  = 1'b1;
                    wr_pulse  = 1'b1;
                    mem_wdata = data_in;
                end
            end
`ifdef ARRAY_MEM_LOADER_VERIFY_EN
            ST_RB_ADDR, ST_RB_CMP: mem_addr = count_reg - ADDR_ONE;
`endif
            ST_FULL:  full = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
            wdata_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (state_reg == ST_WRITE && !at_depth) begin
            count_reg <= count_reg + ADDR_ONE;
            wdata_reg <= data_in;
        end
    end

    assign count = count_reg;

`ifdef ARRAY_MEM_LOADER_VERIFY_EN
    logic verify_err_reg;

    // array_mem has one cycle of read latency, so q for the RB_ADDR address
    // is valid during RB_CMP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            verify_err_reg <= 1'b0;
        end else if (clear) begin
            verify_err_reg <= 1'b0;
        end else if (state_reg == ST_RB_CMP && mem_rdata != wdata_reg) begin
            verify_err_reg <= 1'b1;
        end
    end

    assign verify_err = verify_err_reg;
`else
    logic unused_rdata;

    assign unused_rdata = ^mem_rdata;
    assign verify_err   = 1'b0;
`endif

endmodule

// File: tb/tb_array_mem_loader.sv
// Directed bench for array_mem_loader with a write scoreboard and a model array_mem.
module tb_array_mem_loader;

    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int DB    = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_btn;
    logic          clear;
    logic [DW-1:0] data_in;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wren;
    logic [AW-1:0] count;
    logic          full;
    logic          wr_pulse;
    logic          verify_err;

    logic [DW-1:0] model_mem [0:(1<<AW)-1];
    wr_t           exp_q [$];
    wr_t           mon_e;
    logic [AW-1:0] exp_count;
    int            vectors     = 0;
    int            miscompares = 0;
    int            pulses      = 0;
    logic [DW-1:0] vals [8];
    bit            found;

    always #5 clk = ~clk;

    array_mem_loader #(
        .DATA_W          (DW),
        .ADDR_W          (AW),
        .DEPTH           (DEPTH),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_btn   (load_btn),
        .clear      (clear),
        .data_in    (data_in),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wren   (mem_wren),
        .count      (count),
        .full       (full),
        .wr_pulse   (wr_pulse),
        .verify_err (verify_err)
    );

    // Model array_mem with registered read; address 2 stores corrupted data.
    always @(posedge clk) begin
        if (mem_wren === 1'b1) begin
`ifdef ARRAY_MEM_LOADER_VERIFY_EN
            model_mem[mem_addr] <= (mem_addr == 5'd2) ? ~mem_wdata : mem_wdata;
`else
            model_mem[mem_addr] <= mem_wdata;
`endif
        end
        mem_rdata <= model_mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && mem_wren === 1'b1) begin
            pulses++;
            check("wr_pulse_with_wren", {31'd0, wr_pulse}, 32'd1);
            check("addr_in_range", {31'd0, (mem_addr < AW'(DEPTH))}, 32'd1);
            check("write_expected", {31'd0, (exp_q.size() > 0)}, 32'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("write_addr", {27'd0, mem_addr}, {27'd0, mon_e.addr});
                check("write_data", {24'd0, mem_wdata}, {24'd0, mon_e.data});
                $display("write addr=%0d data=0x%0h", mem_addr, mem_wdata);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic press(input logic [DW-1:0] d, input bit expect_write, input int hold);
        wr_t e;
        data_in = d;
        if (expect_write) begin
            e.addr = exp_count;
            e.data = d;
            exp_q.push_back(e);
            exp_count = exp_count + 1'b1;
        end
        load_btn = 1'b1;
        tick(hold);
        load_btn = 1'b0;
        tick(12);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wren"},  {31'd0, mem_wren},   32'd0);
        check({tag, "_pulse"}, {31'd0, wr_pulse},   32'd0);
        check({tag, "_count"}, {27'd0, count},      32'd0);
        check({tag, "_full"},  {31'd0, full},       32'd0);
        check({tag, "_addr"},  {27'd0, mem_addr},   32'd0);
        check({tag, "_wdata"}, {24'd0, mem_wdata},  32'd0);
        check({tag, "_verr"},  {31'd0, verify_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        load_btn  = 1'b0;
        clear     = 1'b0;
        data_in   = '0;
        exp_count = '0;
        vals      = '{8'h03, 8'hFF, 8'h07, 8'h00, 8'h05, 8'h80, 8'h02, 8'h09};

        tick(3);
        settle();
        check_idle_outputs("reset");
        tick(1);
        rst = 1'b1;

        // Two-cycle glitch must be rejected.
        tick(2);
        load_btn = 1'b1;
        tick(2);
        load_btn = 1'b0;
        tick(12);
        settle();
        check("glitch_count", {27'd0, count}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            press(vals[i], 1'b1, 10);
            settle();
            check("load_count", {27'd0, count}, i + 1);
            check("load_full", {31'd0, full}, (i == 7) ? 32'd1 : 32'd0);
`ifdef ARRAY_MEM_LOADER_VERIFY_EN
            check("verify_err", {31'd0, verify_err}, (i >= 2) ? 32'd1 : 32'd0);
`endif
        end
        check("full_addr_holds_count", {27'd0, mem_addr}, 32'd8);
        check("full_wdata_holds_last", {24'd0, mem_wdata}, 32'h09);
        check("pulse_total", pulses, 32'd8);

        for (int i = 0; i < 3; i++) begin
            press(8'hA0 + 8'(i), 1'b0, 10);
            settle();
            check("full_press_count", {27'd0, count}, 32'd8);
            check("full_press_full", {31'd0, full}, 32'd1);
        end

        tick(1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        settle();
        check("clear_count", {27'd0, count}, 32'd0);
        check("clear_full", {31'd0, full}, 32'd0);
        check("clear_verr", {31'd0, verify_err}, 32'd0);
        exp_count = '0;

        // Held for 100 cycles: still exactly one write.
        press(8'h5A, 1'b1, 100);
        settle();
        check("held_count", {27'd0, count}, 32'd1);
        check("held_pulses", pulses, 32'd9);

        press(8'h11, 1'b1, 10);
        press(8'h22, 1'b1, 10);
        press(8'h33, 1'b1, 10);
        settle();
        check("pre_reset_count", {27'd0, count}, 32'd4);

        // Async reset in the middle of the WRITE cycle.
        data_in = 8'h44;
        mon_e.addr = exp_count;
        mon_e.data = 8'h44;
        exp_q.push_back(mon_e);
        load_btn = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (mem_wren === 1'b1) found = 1'b1;
        end
        check("write_seen_before_reset", {31'd0, found}, 32'd1);
        #1;
        rst      = 1'b0;
        load_btn = 1'b0;
        #1;
        check_idle_outputs("midwrite_reset");
        tick(2);
        rst = 1'b1;
        tick(4);
        exp_count = '0;

        press(8'h66, 1'b1, 10);
        settle();
        check("post_reset_count", {27'd0, count}, 32'd1);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
